// File: rtl/img_sram_responder_if.sv
//------------------------------------------------------------------------------
// Module   : img_sram_intf
// Purpose  : Pixel SRAM access bus between an external master and the responder.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface img_sram_intf;
   logic       write_en;
   logic       sense_en;
   logic [7:0] row;
   logic [7:0] col;
   logic [7:0] din;
   logic [7:0] dout;

   modport slv (input write_en, input sense_en, input row, input col, input din, output dout);
   modport mst (output write_en, output sense_en, output row, output col, output din, input dout);
endinterface

`default_nettype wire

// File: rtl/img_sram_responder.sv
//------------------------------------------------------------------------------
// Module   : img_sram_responder
// Purpose  : Image pixel SRAM with direct access port plus host raster load/unload.
//            Optional macro IMG_SRAM_OOB_CHECK_EN enables range checking and oob.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module img_sram_responder #(
   parameter int MAX_ROWS = 64,
   parameter int MAX_COLS = 64
) (
   input  logic        clk,
   input  logic        rst,
   img_sram_intf.slv   sram,
   input  logic [7:0]  nrows,
   input  logic [7:0]  ncols,
   input  logic        ld_start,
   input  logic        ul_start,
   input  logic        ld_valid,
   input  logic [7:0]  ld_data,
   output logic        ld_ready,
   output logic        ul_valid,
   output logic [7:0]  ul_data,
   input  logic        ul_ready,
   output logic        host_busy,
   output logic        ld_done,
   output logic        ul_done,
   output logic        oob
);

   localparam int c_DEPTH = MAX_ROWS * MAX_COLS;
   localparam int c_AW    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_LOAD     = 2'd1,
      S_UL_PRIME = 2'd2,
      S_UNLOAD   = 2'd3
   } state_t;

   state_t            r_state;
   logic [7:0]        r_row;
   logic [7:0]        r_col;
   logic [7:0]        r_nrows;
   logic [7:0]        r_ncols;
   logic [7:0]        r_ul_data;
   logic              r_ul_last;
   logic [7:0]        r_sram_dout;
   logic [7:0]        r_mem [0:c_DEPTH-1];

   logic              w_sram_oob;
   logic              w_size_bad;
   logic              w_sizes_ok;
   logic              w_ptr_last;
   logic              w_col_wrap;
   logic [7:0]        w_next_row;
   logic [7:0]        w_next_col;
   logic              w_ld_hs;
   logic              w_ul_hs;
   logic [c_AW-1:0]   w_rd_addr;
   logic [7:0]        w_rd_data;
   logic              w_we;
   logic [c_AW-1:0]   w_waddr;
   logic [7:0]        w_wdata;
   logic              w_unused;

   // Coordinates are folded modulo the array size; with range checking on,
   // out-of-range coordinates never reach the memory so the fold is a no-op.
   function automatic logic [c_AW-1:0] f_addr(input logic [7:0] row, input logic [7:0] col);
      int v_lin;
      v_lin = (int'(row) % MAX_ROWS) * MAX_COLS + (int'(col) % MAX_COLS);
      return v_lin[c_AW-1:0];
   endfunction

`ifdef IMG_SRAM_OOB_CHECK_EN
   logic r_oob;
   assign w_sram_oob = (int'(sram.row) >= MAX_ROWS) || (int'(sram.col) >= MAX_COLS);
   assign w_size_bad = (int'(nrows) > MAX_ROWS) || (int'(ncols) > MAX_COLS);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_oob <= 1'b0;
      end else if ((r_state == S_IDLE) && (w_sram_oob || ((ld_start || ul_start) && w_size_bad))) begin
         r_oob <= 1'b1;
      end
   end
   assign oob = r_oob;
`else
   assign w_sram_oob = 1'b0;
   assign w_size_bad = 1'b0;
   assign oob        = 1'b0;
`endif

   assign w_unused   = sram.sense_en;
   assign w_sizes_ok = (nrows != 8'd0) && (ncols != 8'd0) && !w_size_bad;
   assign w_col_wrap = (r_col == r_ncols - 8'd1);
   assign w_ptr_last = w_col_wrap && (r_row == r_nrows - 8'd1);
   assign w_next_col = w_col_wrap ? 8'd0 : r_col + 8'd1;
   assign w_next_row = w_col_wrap ? r_row + 8'd1 : r_row;
   assign w_ld_hs    = (r_state == S_LOAD) && ld_valid;
   assign w_ul_hs    = (r_state == S_UNLOAD) && ul_ready;

   // Single read and single write port, shared between direct access and host streams by state.
   assign w_rd_addr = (r_state == S_IDLE) ? f_addr(sram.row, sram.col) : f_addr(r_row, r_col);
   assign w_rd_data = r_mem[w_rd_addr];

   always_comb begin
      w_we    = 1'b0;
      w_waddr = f_addr(r_row, r_col);
      w_wdata = ld_data;
      if (r_state == S_IDLE) begin
         w_we    = sram.write_en && !w_sram_oob;
         w_waddr = f_addr(sram.row, sram.col);
         w_wdata = sram.din;
      end else if (w_ld_hs) begin
         w_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_row       <= 8'd0;
         r_col       <= 8'd0;
         r_nrows     <= 8'd0;
         r_ncols     <= 8'd0;
         r_ul_data   <= 8'd0;
         r_ul_last   <= 1'b0;
         r_sram_dout <= 8'd0;
      end else begin
         r_sram_dout <= 8'd0;
         case (r_state)
            S_IDLE: begin
               if (w_sram_oob)         r_sram_dout <= 8'd0;
               else if (sram.write_en) r_sram_dout <= sram.din;
               else                    r_sram_dout <= w_rd_data;
               if ((ld_start || ul_start) && w_sizes_ok) begin
                  r_nrows <= nrows;
                  r_ncols <= ncols;
                  r_row   <= 8'd0;
                  r_col   <= 8'd0;
                  r_state <= ld_start ? S_LOAD : S_UL_PRIME;
               end
            end
            S_LOAD: begin
               if (ld_valid) begin
                  r_row <= w_next_row;
                  r_col <= w_next_col;
                  if (w_ptr_last) r_state <= S_IDLE;
               end
            end
            S_UL_PRIME: begin
               r_ul_data <= w_rd_data;
               r_ul_last <= w_ptr_last;
               r_row     <= w_next_row;
               r_col     <= w_next_col;
               r_state   <= S_UNLOAD;
            end
            S_UNLOAD: begin
               // The output register doubles as the read register: refill only on consumption.
               if (ul_ready) begin
                  if (r_ul_last) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_ul_data <= w_rd_data;
                     r_ul_last <= w_ptr_last;
                     r_row     <= w_next_row;
                     r_col     <= w_next_col;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign sram.dout = (r_state == S_IDLE) ? r_sram_dout : 8'd0;
   assign ld_ready  = (r_state == S_LOAD);
   assign ul_valid  = (r_state == S_UNLOAD);
   assign ul_data   = r_ul_data;
   assign host_busy = (r_state != S_IDLE);
   assign ld_done   = !rst && w_ld_hs && w_ptr_last;
   assign ul_done   = !rst && w_ul_hs && r_ul_last;

endmodule

`default_nettype wire

// File: tb/tb_img_sram_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_img_sram_responder
// Purpose  : Self-checking bench for img_sram_responder against a pixel-map model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_img_sram_responder;
   localparam int MR = 64;
   localparam int MC = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] nrows, ncols, ld_data, ul_data;
   logic       ld_start, ul_start, ld_valid, ld_ready, ul_valid, ul_ready;
   logic       host_busy, ld_done, ul_done, oob;

   img_sram_intf sram_if ();

   img_sram_responder #(.MAX_ROWS(MR), .MAX_COLS(MC)) dut (
      .clk       (clk),
      .rst       (rst),
      .sram      (sram_if.slv),
      .nrows     (nrows),
      .ncols     (ncols),
      .ld_start  (ld_start),
      .ul_start  (ul_start),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .ul_valid  (ul_valid),
      .ul_data   (ul_data),
      .ul_ready  (ul_ready),
      .host_busy (host_busy),
      .ld_done   (ld_done),
      .ul_done   (ul_done),
      .oob       (oob)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] mdl [int];   // pixel map keyed by linear address

   function automatic int maddr(input int r, input int c);
      return (r % MR) * MC + (c % MC);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sram_wr(input int r, input int c, input logic [7:0] d);
      bit bad;
      bad = 1'b0;
`ifdef IMG_SRAM_OOB_CHECK_EN
      bad = (r >= MR) || (c >= MC);
`endif
      sram_if.write_en = 1'b1;
      sram_if.row = 8'(r);
      sram_if.col = 8'(c);
      sram_if.din = d;
      tick();
      chk("sram_wr_echo", sram_if.dout, bad ? 8'd0 : d);
      if (!bad) mdl[maddr(r, c)] = d;
      sram_if.write_en = 1'b0;
   endtask

   task automatic sram_rd(input int r, input int c);
      sram_if.write_en = 1'b0;
      sram_if.row = 8'(r);
      sram_if.col = 8'(c);
      tick();
      if (mdl.exists(maddr(r, c))) chk("sram_rd", sram_if.dout, mdl[maddr(r, c)]);
   endtask

   task automatic load_img(input int nr, input int nc, input logic [7:0] px[$], input bit gaps);
      int idx, cyc;
      nrows = 8'(nr); ncols = 8'(nc);
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      chk("ld_ready_on", ld_ready, 1);
      chk("ld_busy_on", host_busy, 1);
      idx = 0; cyc = 0;
      while (idx < nr * nc && cyc < 2000) begin
         ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         ld_data  = px[idx];
         #1;
         chk("ld_ready", ld_ready, 1);
         chk("ld_done", ld_done, ld_valid && (idx == nr * nc - 1));
         if (ld_valid) begin
            mdl[maddr(idx / nc, idx % nc)] = px[idx];
            idx++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      ld_valid = 1'b0;
      chk("ld_timeout", idx, nr * nc);
      chk("ld_ready_off", ld_ready, 0);
      chk("ld_busy_off", host_busy, 0);
   endtask

   task automatic unload_img(input int nr, input int nc, input int mode);
      logic [7:0] exp_q[$];
      bit         pat [4];
      int         idx, cyc;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < nr * nc; i++) exp_q.push_back(mdl[maddr(i / nc, i % nc)]);
      nrows = 8'(nr); ncols = 8'(nc);
      ul_start = 1'b1;
      tick();
      ul_start = 1'b0;
      chk("ul_prime_valid", ul_valid, 0);
      chk("ul_prime_busy", host_busy, 1);
      tick();
      idx = 0; cyc = 0;
      while (idx < nr * nc && cyc < 2000) begin
         ul_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
         #1;
         chk("ul_valid", ul_valid, 1);
         chk("ul_data", ul_data, exp_q[idx]);
         chk("ul_done", ul_done, ul_ready && (idx == nr * nc - 1));
         if (ul_ready) idx++;
         @(posedge clk); #1;
         cyc++;
      end
      ul_ready = 1'b0;
      chk("ul_timeout", idx, nr * nc);
      chk("ul_valid_off", ul_valid, 0);
      chk("ul_busy_off", host_busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] px[$];
      int         nr, nc;

      rst = 1'b1;
      nrows = 8'd0; ncols = 8'd0; ld_start = 1'b0; ul_start = 1'b0;
      ld_valid = 1'b0; ld_data = 8'd0; ul_ready = 1'b0;
      sram_if.write_en = 1'b0; sram_if.sense_en = 1'b0;
      sram_if.row = 8'd0; sram_if.col = 8'd0; sram_if.din = 8'd0;
      tick(); tick();
      chk("rst_busy", host_busy, 0);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_ul_valid", ul_valid, 0);
      chk("rst_ld_done", ld_done, 0);
      chk("rst_ul_done", ul_done, 0);
      chk("rst_oob", oob, 0);
      chk("rst_dout", sram_if.dout, 0);
      chk("rst_ul_data", ul_data, 0);
      rst = 1'b0;
      tick();

      // zero-size starts are ignored
      nrows = 8'd0; ncols = 8'd3; ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      chk("zero_rows_ignored", host_busy, 0);
      nrows = 8'd2; ncols = 8'd0; ul_start = 1'b1;
      tick();
      ul_start = 1'b0;
      chk("zero_cols_ignored", host_busy, 0);

      // 2x3 load of 1..6, then direct read-back and unloads
      px = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
      load_img(2, 3, px, 1'b0);
      sram_rd(1, 2);
      sram_rd(0, 0);
      unload_img(2, 3, 0);
      unload_img(2, 3, 1);

      // simultaneous starts: load wins; reset mid-load keeps written pixels
      nrows = 8'd2; ncols = 8'd3; ld_start = 1'b1; ul_start = 1'b1;
      tick();
      ld_start = 1'b0; ul_start = 1'b0;
      chk("both_start_load", ld_ready, 1);
      chk("both_start_no_ul", ul_valid, 0);
      for (int k = 0; k < 3; k++) begin
         ld_valid = 1'b1;
         ld_data  = 8'(11 + k);
         tick();
         mdl[maddr(0, k)] = 8'(11 + k);
         chk("mid_ul_valid", ul_valid, 0);
      end
      rst = 1'b1; ld_data = 8'hEE;
      tick();
      rst = 1'b0; ld_valid = 1'b0;
      chk("midrst_busy", host_busy, 0);
      chk("midrst_ld_ready", ld_ready, 0);
      chk("midrst_ul_data", ul_data, 0);
      chk("midrst_dout", sram_if.dout, 0);
      tick();
      chk("midrst_ul_never", ul_valid, 0);
      sram_rd(0, 0); sram_rd(0, 1); sram_rd(0, 2); sram_rd(1, 0);

      // direct writes are ignored while busy
      sram_wr(5, 5, 8'h33);
      nrows = 8'd1; ncols = 8'd2; ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      sram_if.write_en = 1'b1; sram_if.row = 8'd5; sram_if.col = 8'd5; sram_if.din = 8'h5A;
      tick();
      chk("busy_wr_dout", sram_if.dout, 0);
      sram_if.write_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ld_valid = 1'b1;
         ld_data  = 8'(40 + k);
         tick();
         mdl[maddr(0, k)] = 8'(40 + k);
      end
      ld_valid = 1'b0;
      chk("busy_wr_load_done", host_busy, 0);
      sram_rd(5, 5);

      // out-of-range access
      sram_wr(64, 0, 8'hAA);
`ifdef IMG_SRAM_OOB_CHECK_EN
      chk("oob_set", oob, 1);
      sram_rd(64, 0);
      chk("oob_rd_zero", sram_if.dout, 0);
      nrows = 8'd65; ncols = 8'd1; ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      chk("oob_size_reject", host_busy, 0);
      sram_rd(0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("oob_rst_clear", oob, 0);
`else
      chk("oob_tied", oob, 0);
      sram_rd(0, 0);
      chk("wrap_lands_00", sram_if.dout, 8'hAA);
`endif

      // random direct traffic
      for (int k = 0; k < 12; k++) begin
         nr = int'($urandom_range(0, MR - 1));
         nc = int'($urandom_range(0, MC - 1));
         if ($urandom_range(0, 1) == 1) sram_wr(nr, nc, 8'($urandom));
         sram_rd(nr, nc);
      end

      // random host transfers, first one a single pixel
      for (int k = 0; k < 5; k++) begin
         nr = (k == 0) ? 1 : int'($urandom_range(1, 4));
         nc = (k == 0) ? 1 : int'($urandom_range(1, 6));
         px.delete();
         for (int i = 0; i < nr * nc; i++) px.push_back(8'($urandom));
         load_img(nr, nc, px, 1'b1);
         unload_img(nr, nc, 2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
